// File: rtl/gray_colormap_pkg.sv
// Shared types and helpers for the grayscale-to-RGB colormap engine.
// Contents: FSM state enum, default-width RGB struct, gray-to-channel scaling function.
package gray_colormap_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned RgbChW = 8;

  typedef struct packed {
    logic [RgbChW-1:0] r;
    logic [RgbChW-1:0] g;
    logic [RgbChW-1:0] b;
  } rgb_t;

  // MSB-aligned rescale of a gray_w-bit value to ch_w bits. Output bit at distance k from the MSB
  // takes source bit (k mod gray_w) from the MSB: this replicates MSBs when widening and drops
  // LSBs when narrowing, so full scale maps to full scale.
  function automatic logic [31:0] gray_to_ch(input logic [31:0] gray,
                                             input int unsigned gray_w,
                                             input int unsigned ch_w);
    logic [31:0] res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < ch_w) begin
        k = (ch_w - 1 - i) % gray_w;
        res[i] = gray[gray_w - 1 - k];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/colormap_ram.sv
// Simple dual-port table storage: one write port, one synchronous read port with read enable.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (registered read data).
// Storage has no reset. A read and write to the same entry in one cycle returns the old data.
module colormap_ram #(
  parameter int unsigned DataW = 24,
  parameter int unsigned AddrW = 10,
  parameter int unsigned Depth = 1024
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Held when re is low so a stalled pipeline keeps its fetched entry.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gray_colormap_lut.sv
// Streaming grayscale-to-RGB pseudo-colour engine with run-time-loadable colormap tables.
// Ports: clk/rst (sync, active-high); s_* grayscale input stream with valid/ready and sof;
// map_sel/bypass map selection latched on accepted sof; cfg_* table write port;
// m_* RGB output stream with valid/ready and aligned sof. Latency 2 cycles, 1 pixel/cycle.
module gray_colormap_lut
  import gray_colormap_pkg::*;
#(
  parameter int unsigned GRAY_W   = 8,
  parameter int unsigned CH_W     = 8,
  parameter int unsigned NUM_MAPS = 4,
  localparam int unsigned MAP_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [GRAY_W-1:0] s_gray,
  input  logic              s_sof,
  input  logic [MAP_W-1:0]  map_sel,
  input  logic              bypass,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [MAP_W-1:0]  cfg_map,
  input  logic [GRAY_W-1:0] cfg_addr,
  input  logic [3*CH_W-1:0] cfg_rgb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_r,
  output logic [CH_W-1:0]   m_g,
  output logic [CH_W-1:0]   m_b,
  output logic              m_sof
);

  localparam int unsigned AddrW = MAP_W + GRAY_W;
  localparam int unsigned Depth = NUM_MAPS * (2 ** GRAY_W);
  localparam int unsigned RgbW  = 3 * CH_W;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);
  localparam logic [MAP_W-1:0] MaxMap   = MAP_W'(NUM_MAPS - 1);

  state_e            state_q, state_d;
  logic [AddrW-1:0]  cnt_q, cnt_d;
  logic              run, en, accept;

  logic [MAP_W-1:0]  act_map_q;
  logic              act_byp_q;
  logic [MAP_W-1:0]  sel_clamped, cur_map;
  logic              cur_byp, cfg_map_ok;

  logic              s1_valid_q, s1_sof_q, s1_byp_q;
  logic [GRAY_W-1:0] s1_gray_q;
  logic              m_valid_q, m_sof_q;
  logic [RgbW-1:0]   m_rgb_q;

  logic              ram_we;
  logic [AddrW-1:0]  ram_waddr, ram_raddr;
  logic [RgbW-1:0]   ram_wdata, ram_rdata;
  logic [CH_W-1:0]   init_ch, byp_ch;

  // Range checks only exist when NUM_MAPS leaves unused map codes.
  if ((2 ** MAP_W) == NUM_MAPS) begin : g_full_maps
    assign sel_clamped = map_sel;
    assign cfg_map_ok  = 1'b1;
  end else begin : g_partial_maps
    assign sel_clamped = (map_sel > MaxMap) ? MaxMap : map_sel;
    assign cfg_map_ok  = (cfg_map <= MaxMap);
  end

  assign run       = (state_q == StRun);
  assign en        = !m_valid_q || m_ready;
  assign s_ready   = run && en;
  assign cfg_ready = run;
  assign accept    = s_valid && s_ready;

  // The sof pixel itself already uses the newly requested selection.
  assign cur_map = s_sof ? sel_clamped : act_map_q;
  assign cur_byp = s_sof ? bypass : act_byp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_map_q <= '0;
      act_byp_q <= 1'b0;
    end else if (accept && s_sof) begin
      act_map_q <= sel_clamped;
      act_byp_q <= bypass;
    end
  end

  // INIT loads an identity ramp into every table, one entry per cycle; the low GRAY_W counter
  // bits are the entry index, the high bits the map index.
  assign init_ch   = CH_W'(gray_to_ch(32'(cnt_q[GRAY_W-1:0]), GRAY_W, CH_W));
  assign ram_we    = run ? (cfg_we && cfg_map_ok) : 1'b1;
  assign ram_waddr = run ? {cfg_map, cfg_addr} : cnt_q;
  assign ram_wdata = run ? cfg_rgb : {init_ch, init_ch, init_ch};
  assign ram_raddr = {cur_map, s_gray};

  colormap_ram #(
    .DataW (RgbW),
    .AddrW (AddrW),
    .Depth (Depth)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (en),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign byp_ch = CH_W'(gray_to_ch(32'(s1_gray_q), GRAY_W, CH_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_gray_q  <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_rgb_q    <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      s1_sof_q   <= s_sof;
      s1_byp_q   <= cur_byp;
      s1_gray_q  <= s_gray;
      m_valid_q  <= s1_valid_q;
      m_sof_q    <= s1_valid_q && s1_sof_q;
      m_rgb_q    <= s1_byp_q ? {byp_ch, byp_ch, byp_ch} : ram_rdata;
    end
  end

  assign m_valid = m_valid_q;
  assign m_sof   = m_sof_q;
  assign m_r     = m_rgb_q[3*CH_W-1:2*CH_W];
  assign m_g     = m_rgb_q[2*CH_W-1:CH_W];
  assign m_b     = m_rgb_q[CH_W-1:0];

endmodule
